pulse_seq: RTL and testbench

PULSE_SEQ -- requirements
Module: pulse_seq

---
 rtl/pulse_seq_if.sv | 13 +
 rtl/pulse_seq.sv | 143 ++++++++++++++
 tb/tb_pulse_seq.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pulse_seq_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// pulse_seq_if : delay-table RAM read port (1-cycle read latency)   Rev 1.0
//------------------------------------------------------------------------------
interface pulse_seq_if;
  logic [2:0] rd_addr;
  logic       rd_en;
  logic [7:0] rd_data;

  modport master (output rd_addr, output rd_en, input  rd_data);
  modport slave  (input  rd_addr, input  rd_en, output rd_data);
endinterface
`default_nettype wire

// File: rtl/pulse_seq.sv
`default_nettype none
//------------------------------------------------------------------------------
// pulse_seq : 8-channel delayed optical sync pulse sequencer; option macro
//             PULSE_SEQ_REPEAT_EN reloads and reruns continuously.   Rev 1.0
//------------------------------------------------------------------------------
module pulse_seq #(
  parameter int DIV     = 50,
  parameter int PULSE_W = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stop,
  pulse_seq_if.master ram,
  output logic [7:0]  pulse,
  output logic        busy,
  output logic        done
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [15:0] DIV_LAST = 16'(DIV - 1);
  localparam logic [15:0] WIDTH    = 16'(PULSE_W);

  logic [2:0]  state;
  logic [3:0]  lcnt;
  logic [15:0] presc;
  logic [7:0]  t;
  logic [7:0]  active;
  logic        abort;
  logic        tick_wrap;
  logic        tick0;
  logic        cap_en;
  logic [2:0]  cap_addr;

  assign abort     = stop && (state == S_LOAD || state == S_RUN || state == S_DRAIN);
  assign tick_wrap = (presc == DIV_LAST);
  assign tick0     = (state == S_RUN) && (presc == 16'd0);
  // read data lags the strobe by one clock, so capture uses the previous address
  assign cap_en    = (state == S_LOAD) && (lcnt != 4'd0) && !stop;
  assign cap_addr  = 3'(lcnt - 4'd1);

  assign ram.rd_en   = (state == S_LOAD) && !lcnt[3];
  assign ram.rd_addr = ram.rd_en ? lcnt[2:0] : 3'd0;
  assign busy        = (state != S_IDLE);
  assign done        = (state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      lcnt  <= 4'd0;
      presc <= 16'd0;
      t     <= 8'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && !stop) begin
            state <= S_LOAD;
            lcnt  <= 4'd0;
          end
        end
        S_LOAD: begin
          if (stop) begin
            state <= S_IDLE;
          end else if (lcnt == 4'd8) begin
            state <= S_RUN;
            lcnt  <= 4'd0;
            presc <= 16'd0;
            t     <= 8'd0;
          end else begin
            lcnt <= lcnt + 4'd1;
          end
        end
        S_RUN: begin
          if (stop) begin
            state <= S_IDLE;
          end else if (tick_wrap) begin
            presc <= 16'd0;
            // the last tick ends the run instead of wrapping t
            if (t == 8'hFF) state <= S_DRAIN;
            else            t     <= t + 8'd1;
          end else begin
            presc <= presc + 16'd1;
          end
        end
        S_DRAIN: begin
          if (stop)                 state <= S_IDLE;
          else if (active == 8'd0)  state <= S_DONE;
        end
        S_DONE: begin
`ifdef PULSE_SEQ_REPEAT_EN
          if (stop) begin
            state <= S_IDLE;
          end else begin
            state <= S_LOAD;
            lcnt  <= 4'd0;
          end
`else
          state <= S_IDLE;
`endif
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  for (genvar k = 0; k < 8; k++) begin : g_ch
    logic [7:0]  delay;
    logic [15:0] wcnt;
    logic        p_q;
    logic        fire;

    assign fire      = tick0 && (t == delay) && (delay != 8'hFF);
    assign pulse[k]  = p_q;
    assign active[k] = (wcnt != 16'd0);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        delay <= 8'd0;
        wcnt  <= 16'd0;
        p_q   <= 1'b0;
      end else begin
        if (cap_en && cap_addr == 3'(k)) delay <= ram.rd_data;
        if (abort) begin
          wcnt <= 16'd0;
          p_q  <= 1'b0;
        end else if (fire) begin
          wcnt <= WIDTH;
          p_q  <= 1'b1;
        end else if (wcnt != 16'd0) begin
          wcnt <= wcnt - 16'd1;
          p_q  <= (wcnt != 16'd1);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pulse_seq.sv
`default_nettype none
//------------------------------------------------------------------------------
// tb_pulse_seq : directed self-checking bench for pulse_seq          Rev 1.0
//------------------------------------------------------------------------------
module tb_pulse_seq;

`ifdef PULSE_SEQ_REPEAT_EN
  localparam logic REP = 1'b1;
`else
  localparam logic REP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_a = 1'b0;
  logic       start_b = 1'b0;
  logic       stop = 1'b0;
  logic [7:0] pulse_a, pulse_b;
  logic       busy_a, busy_b, done_a, done_b;
  logic [7:0] mem [8];
  logic [7:0] seen_a = 8'd0;
  int         cyc = 0;
  int         n_checks = 0;
  int         n_fail = 0;
  int         done_cnt_a = 0;
  int         done_cnt_b = 0;
  int         snap;

  pulse_seq_if ram_a ();
  pulse_seq_if ram_b ();

  pulse_seq #(.DIV(4), .PULSE_W(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .stop(stop), .ram(ram_a),
    .pulse(pulse_a), .busy(busy_a), .done(done_a)
  );

  pulse_seq #(.DIV(4), .PULSE_W(20)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .stop(stop), .ram(ram_b),
    .pulse(pulse_b), .busy(busy_b), .done(done_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_a.rd_en) ram_a.rd_data <= mem[ram_a.rd_addr];
    if (ram_b.rd_en) ram_b.rd_data <= mem[ram_b.rd_addr];
    if (done_a) done_cnt_a <= done_cnt_a + 1;
    if (done_b) done_cnt_b <= done_cnt_b + 1;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    seen_a = seen_a | pulse_a;
  endtask

  task automatic go_to(input int n);
    while (cyc < n) tick();
  endtask

  // cyc = 0 right after the edge that samples start
  task automatic kick(input logic which_b);
    if (which_b) start_b = 1'b1;
    else         start_a = 1'b1;
    tick();
    start_a = 1'b0;
    start_b = 1'b0;
    cyc     = 0;
    seen_a  = 8'd0;
  endtask

  task automatic abort_run();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic fill(input logic [7:0] v);
    for (int i = 0; i < 8; i++) mem[i] = v;
  endtask

  initial begin
    fill(8'hFF);
    repeat (3) @(posedge clk);
    #1;
    check("reset_pulse",   32'(pulse_a),       32'h0);
    check("reset_busy",    32'(busy_a),        32'h0);
    check("reset_done",    32'(done_a),        32'h0);
    check("reset_rd_en",   32'(ram_a.rd_en),   32'h0);
    check("reset_rd_addr", 32'(ram_a.rd_addr), 32'h0);
    rst_n = 1'b1;

    // ascending table, start on the very first edge after reset release
    for (int i = 0; i < 8; i++) mem[i] = 8'(i);
    kick(1'b0);
    check("load_busy",   32'(busy_a),        32'h1);
    check("load_rd_en0", 32'(ram_a.rd_en),   32'h1);
    check("load_addr0",  32'(ram_a.rd_addr), 32'h0);
    go_to(7);
    check("load_addr7",  32'(ram_a.rd_addr), 32'h7);
    check("load_rd_en7", 32'(ram_a.rd_en),   32'h1);
    go_to(8);
    check("load_rd_en8", 32'(ram_a.rd_en),   32'h0);
    check("load_addr8",  32'(ram_a.rd_addr), 32'h0);
    for (int k = 0; k < 8; k++) begin
      go_to(9 + 4 * k);
      check($sformatf("asc_pre%0d", k),  32'(pulse_a), 32'h0);
      go_to(10 + 4 * k);
      check($sformatf("asc_rise%0d", k), 32'(pulse_a), 32'(8'h1 << k));
      go_to(11 + 4 * k);
      check($sformatf("asc_high%0d", k), 32'(pulse_a), 32'(8'h1 << k));
      go_to(12 + 4 * k);
      check($sformatf("asc_fall%0d", k), 32'(pulse_a), 32'h0);
    end
    go_to(1033);
    check("asc_done_early", 32'(done_a), 32'h0);
    check("asc_drain_busy", 32'(busy_a), 32'h1);
    go_to(1034);
    check("asc_done",       32'(done_a), 32'h1);
    go_to(1035);
    check("asc_done_once",  32'(done_a), 32'h0);
    check("asc_busy_after", 32'(busy_a), 32'(REP));
    abort_run();
    check("asc_done_count", 32'(done_cnt_a), 32'd1);

    // every channel disabled
    fill(8'hFF);
    kick(1'b0);
    go_to(1033);
    check("ff_done_early", 32'(done_a), 32'h0);
    go_to(1034);
    check("ff_done",       32'(done_a), 32'h1);
    check("ff_no_pulse",   32'(seen_a), 32'h0);
    abort_run();

    // channels 3 and 5 share delay 0x10: rise at 10 + 4*16
    fill(8'hFF);
    mem[3] = 8'h10;
    mem[5] = 8'h10;
    kick(1'b0);
    go_to(73);
    check("eq_pre",  32'(pulse_a), 32'h0);
    go_to(74);
    check("eq_rise", 32'(pulse_a), 32'h28);
    go_to(75);
    check("eq_high", 32'(pulse_a), 32'h28);
    go_to(76);
    check("eq_fall", 32'(pulse_a), 32'h0);
    abort_run();

    // stop while pulse[2] is high
    fill(8'hFF);
    mem[2] = 8'h03;
    snap = done_cnt_a;
    kick(1'b0);
    go_to(22);
    check("stop_pulse_hi", 32'(pulse_a), 32'h04);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("stop_pulse", 32'(pulse_a), 32'h0);
    check("stop_busy",  32'(busy_a),  32'h0);
    check("stop_done",  32'(done_a),  32'h0);
    go_to(40);
    check("stop_no_done", 32'(done_cnt_a - snap), 32'h0);

    // asynchronous reset in the middle of LOAD
    kick(1'b0);
    go_to(3);
    check("rst_pre_rd_en", 32'(ram_a.rd_en), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_rd_en",   32'(ram_a.rd_en),   32'h0);
    check("rst_rd_addr", 32'(ram_a.rd_addr), 32'h0);
    check("rst_busy",    32'(busy_a),        32'h0);
    check("rst_pulse",   32'(pulse_a),       32'h0);
    check("rst_done",    32'(done_a),        32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("rst_idle", 32'(busy_a), 32'h0);

    // 8'hFF disables a channel, so 254 is the latest delay that still fires:
    // rise at 10 + 4*254 = 1026, 20 clocks high, outlasting RUN (ends at 1033)
    fill(8'hFF);
    mem[0] = 8'hFE;
    snap = done_cnt_b;
    kick(1'b1);
    go_to(1039);
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    go_to(1045);
    check("drain_pulse_hi", 32'(pulse_b), 32'h01);
    check("drain_busy",     32'(busy_b),  32'h1);
    check("drain_no_done",  32'(done_b),  32'h0);
    go_to(1046);
    check("drain_pulse_lo", 32'(pulse_b), 32'h0);
    check("drain_wait",     32'(done_b),  32'h0);
    go_to(1047);
    check("drain_done",     32'(done_b),  32'h1);
    go_to(1048);
    check("drain_busy_after", 32'(busy_b), 32'(REP));
    check("drain_done_count", 32'(done_cnt_b - snap), 32'd1);
    abort_run();

`ifdef PULSE_SEQ_REPEAT_EN
    // three back-to-back periods of 1035 clocks each
    fill(8'hFF);
    snap = done_cnt_a;
    kick(1'b0);
    go_to(1034);
    check("rep_done1",   32'(done_a),      32'h1);
    go_to(1035);
    check("rep_reload",  32'(ram_a.rd_en), 32'h1);
    go_to(2069);
    check("rep_done2",   32'(done_a),      32'h1);
    go_to(3104);
    check("rep_done3",   32'(done_a),      32'h1);
    go_to(3105);
    check("rep_count",   32'(done_cnt_a - snap), 32'd3);
    abort_run();
    check("rep_stop_idle", 32'(busy_a), 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
